// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment patterns, blank code and scan-index type
package seg7_pkg;

  typedef logic [1:0] scan_idx_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Active-high patterns, bit0=a .. bit6=g
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational nibble-to-segment decoder with dp passthrough
module seg7_decode
  import seg7_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic [3:0] nibble_i,
  input  logic       dp_req_i,
  output logic [6:0] seg_o,
  output logic       dp_o
);

  logic [6:0] pattern;

  // 4'hF is the blank-digit code, not the letter F
  always_comb begin
    pattern = SEG_BLANK;
    case (nibble_i)
      4'h0:       pattern = SEG_0;
      4'h1:       pattern = SEG_1;
      4'h2:       pattern = SEG_2;
      4'h3:       pattern = SEG_3;
      4'h4:       pattern = SEG_4;
      4'h5:       pattern = SEG_5;
      4'h6:       pattern = SEG_6;
      4'h7:       pattern = SEG_7;
      4'h8:       pattern = SEG_8;
      4'h9:       pattern = SEG_9;
      4'hA:       pattern = SEG_A;
      4'hB:       pattern = SEG_B;
      4'hC:       pattern = SEG_C;
      4'hD:       pattern = SEG_D;
      4'hE:       pattern = SEG_E;
      BLANK_CODE: pattern = SEG_BLANK;
      default:    pattern = SEG_BLANK;
    endcase
  end

  assign seg_o = SEG_ACTIVE_LOW ? ~pattern : pattern;
  assign dp_o  = SEG_ACTIVE_LOW ? ~dp_req_i : dp_req_i;

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit multiplexed 7-segment scanner and decoder
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  output logic [3:0]  select,
  output logic [6:0]  seg7,
  output logic        dp,
  output logic [1:0]  scan_idx
);

  scan_idx_t scan_idx_q;
  scan_idx_t scan_idx_d;

  assign scan_idx_d = scan_idx_q + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_idx_q <= '0;
    end else begin
      scan_idx_q <= scan_idx_d;
    end
  end

  assign scan_idx = scan_idx_q;
  assign select   = ~(4'b0001 << scan_idx_q);

  // Mux is combinational so a live input change on the active digit shows at once
  logic [3:0] cur_nibble;
  logic       cur_dp;

  assign cur_nibble = digits[{scan_idx_q, 2'b00} +: 4];
  assign cur_dp     = dp_in[scan_idx_q];

  seg7_decode #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_decode (
    .nibble_i(cur_nibble),
    .dp_req_i(cur_dp),
    .seg_o   (seg7),
    .dp_o    (dp)
  );

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits = '0;
  logic [3:0]  dp_in = '0;

  logic [3:0] sel, sel_al;
  logic [6:0] seg, seg_al;
  logic       dp, dp_al;
  logic [1:0] idx, idx_al;

  int vectors = 0;
  int errors  = 0;
  int m_idx   = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h00};

  seg7_scan_driver #(.SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .digits(digits), .dp_in(dp_in),
    .select(sel), .seg7(seg), .dp(dp), .scan_idx(idx)
  );

  seg7_scan_driver #(.SEG_ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .digits(digits), .dp_in(dp_in),
    .select(sel_al), .seg7(seg_al), .dp(dp_al), .scan_idx(idx_al)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_sel(input int i);
    logic [3:0] one_cold;
    one_cold = 4'b1111;
    one_cold[i] = 1'b0;
    return one_cold;
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] d, input int i);
    return seg_tab[(d >> (4 * i)) & 16'hF];
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst) m_idx = (m_idx + 1) % 4;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_idx = 0; digits = 16'h0000; dp_in = 4'b0000;
    #1;
    vectors++;
    if (sel !== 4'b1110 || idx !== 2'd0) begin
      errors++; $display("FAIL reset_init: got sel=%b idx=%0d expected sel=1110 idx=0", sel, idx);
    end
    rst = 1'b0;
    step(); step();
    vectors++;
    if (idx !== 2'd2 || sel !== 4'b1011) begin
      errors++; $display("FAIL reset_prescan: got sel=%b idx=%0d expected sel=1011 idx=2", sel, idx);
    end
    #2; rst = 1'b1; m_idx = 0; #1;
    vectors++;
    if (sel !== 4'b1110 || idx !== 2'd0 || seg !== 7'h3F) begin
      errors++; $display("FAIL reset_async: got sel=%b idx=%0d seg=%h expected sel=1110 idx=0 seg=3f", sel, idx, seg);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if (sel !== 4'b1110 || idx !== 2'd0) begin
        errors++; $display("FAIL reset_hold%0d: got sel=%b idx=%0d expected sel=1110 idx=0", c, sel, idx);
      end
    end
    rst = 1'b0;
    step();
    vectors++;
    if (sel !== 4'b1101 || idx !== 2'd1) begin
      errors++; $display("FAIL reset_release: got sel=%b idx=%0d expected sel=1101 idx=1", sel, idx);
    end
  endtask

  task automatic test_rotation();
    rst = 1'b1; m_idx = 0; #1; rst = 1'b0;
    digits = 16'h4321; dp_in = 4'b0000;
    for (int c = 0; c < 8; c++) begin
      #1;
      vectors++;
      if (sel !== exp_sel(m_idx) || idx !== 2'(m_idx) || seg !== seg_tab[m_idx + 1] || dp !== 1'b0) begin
        errors++;
        $display("FAIL rotation%0d: got sel=%b idx=%0d seg=%h dp=%b expected sel=%b idx=%0d seg=%h dp=0",
                 c, sel, idx, seg, dp, exp_sel(m_idx), m_idx, seg_tab[m_idx + 1]);
      end
      step();
    end
  endtask

  task automatic test_full_decode();
    rst = 1'b1; m_idx = 0; dp_in = 4'b0000;
    for (int v = 0; v < 16; v++) begin
      digits = 16'(v);
      #1;
      vectors++;
      if (seg !== seg_tab[v] || seg_al !== ~seg_tab[v] || sel !== 4'b1110) begin
        errors++;
        $display("FAIL decode_%h: got seg=%h seg_al=%h sel=%b expected seg=%h seg_al=%h sel=1110",
                 v, seg, seg_al, sel, seg_tab[v], ~seg_tab[v]);
      end
    end
  endtask

  task automatic test_blank_dp();
    rst = 1'b1; m_idx = 0; #1; rst = 1'b0;
    digits = 16'hFFFF; dp_in = 4'b0010;
    for (int c = 0; c < 8; c++) begin
      #1;
      vectors++;
      if (seg !== 7'h00 || dp !== (m_idx == 1) || dp_al !== (m_idx != 1) || sel !== exp_sel(m_idx)) begin
        errors++;
        $display("FAIL blank_dp%0d: got seg=%h dp=%b dp_al=%b sel=%b expected seg=00 dp=%b sel=%b",
                 c, seg, dp, dp_al, sel, (m_idx == 1), exp_sel(m_idx));
      end
      step();
    end
  endtask

  task automatic test_live_update();
    rst = 1'b0; digits = 16'h0000; dp_in = 4'b0000;
    for (int c = 0; c < 4 && m_idx != 3; c++) step();
    vectors++;
    if (idx !== 2'd3) begin
      errors++; $display("FAIL live_reach: got idx=%0d expected idx=3", idx);
    end
    digits = 16'h8000; #1;
    vectors++;
    if (seg !== 7'h7F) begin
      errors++; $display("FAIL live_8: got seg=%h expected seg=7f", seg);
    end
    digits = 16'h0000; #1;
    vectors++;
    if (seg !== 7'h3F || idx !== 2'd3) begin
      errors++; $display("FAIL live_0: got seg=%h idx=%0d expected seg=3f idx=3", seg, idx);
    end
  endtask

  task automatic test_polarity();
    rst = 1'b1; m_idx = 0;
    digits = 16'h0001; dp_in = 4'b0001; #1;
    vectors++;
    if (seg_al !== 7'h79 || dp_al !== 1'b0 || sel_al !== 4'b1110) begin
      errors++; $display("FAIL polarity: got seg=%h dp=%b sel=%b expected seg=79 dp=0 sel=1110", seg_al, dp_al, sel_al);
    end
    digits = 16'hFFFF; dp_in = 4'b0000; #1;
    vectors++;
    if (seg_al !== 7'h7F || dp_al !== 1'b1) begin
      errors++; $display("FAIL polarity_blank: got seg=%h dp=%b expected seg=7f dp=1", seg_al, dp_al);
    end
  endtask

  task automatic test_random();
    rst = 1'b1; m_idx = 0; #1; rst = 1'b0;
    for (int c = 0; c < 200; c++) begin
      digits = 16'($urandom);
      dp_in  = 4'($urandom);
      #1;
      vectors++;
      if (sel !== exp_sel(m_idx) || idx !== 2'(m_idx) || sel_al !== exp_sel(m_idx)
          || seg !== exp_seg(digits, m_idx) || dp !== dp_in[m_idx]
          || seg_al !== ~exp_seg(digits, m_idx) || dp_al !== ~dp_in[m_idx]) begin
        errors++;
        $display("FAIL random%0d: got sel=%b idx=%0d seg=%h dp=%b seg_al=%h dp_al=%b expected sel=%b idx=%0d seg=%h dp=%b",
                 c, sel, idx, seg, dp, seg_al, dp_al, exp_sel(m_idx), m_idx, exp_seg(digits, m_idx), dp_in[m_idx]);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_full_decode();
    test_blank_dp();
    test_live_update();
    test_polarity();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
